// File: rtl/multiplier_if.sv
// rtl/multiplier_if.sv - operand/start/result bundle for the radix-4 multiplier
interface multiplier_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        sign;
    logic [63:0] result;
    logic        busy;

    modport master (
        output A, B, start, sign,
        input  result, busy
    );

    modport slave (
        input  A, B, start, sign,
        output result, busy
    );
endinterface

// File: rtl/multiplier.sv
// rtl/multiplier.sv - radix-4 sequential multiplier, signed/unsigned, early exit
module multiplier (
    input  logic        clk,
    input  logic        reset,
    multiplier_if.slave bus
);
    logic [63:0] acc;
    logic [63:0] mc1;
    logic [63:0] mc2;
    logic [63:0] mc3;
    logic [31:0] rem;
    logic        neg;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] addend;

    // Negating 0x80000000 in 32 bits gives 0x80000000 again, which is the correct unsigned 2^31.
    always_comb begin
        mag_a = (bus.sign && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
        mag_b = (bus.sign && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
        case (rem[1:0])
            2'd0:    addend = 64'd0;
            2'd1:    addend = mc1;
            2'd2:    addend = mc2;
            default: addend = mc3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= 64'd0;
            mc1 <= 64'd0;
            mc2 <= 64'd0;
            mc3 <= 64'd0;
            rem <= 32'd0;
            neg <= 1'b0;
        end else if (bus.start) begin
            acc <= 64'd0;
            mc1 <= {32'd0, mag_a};
            mc2 <= {31'd0, mag_a, 1'b0};
            mc3 <= {32'd0, mag_a} + {31'd0, mag_a, 1'b0};
            rem <= mag_b;
            neg <= bus.sign & (bus.A[31] ^ bus.B[31]);
        end else if (rem != 32'd0) begin
            acc <= acc + addend;
            mc1 <= mc1 << 2;
            mc2 <= mc2 << 2;
            mc3 <= mc3 << 2;
            rem <= rem >> 2;
        end
    end

    // Iteration stops once the remaining multiplier drains, so busy is just its nonzero flag.
    assign bus.busy   = (rem != 32'd0);
    assign bus.result = neg ? (~acc + 64'd1) : acc;
endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - vector table, random model checks and corner sequences for multiplier
module tb_multiplier;
    logic clk;
    logic reset;
    multiplier_if bus ();

    multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          cyc;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic int model_cycles(input logic [31:0] b, input logic s);
        logic [32:0] mag;
        int bitlen;
        mag = (s && b[31]) ? {1'b0, -b} : {1'b0, b};
        if (s && b == 32'h8000_0000) mag = 33'h0_8000_0000;
        bitlen = $clog2(mag + 33'd1);
        return (bitlen + 1) / 2;
    endfunction

    // Launch one multiply and count busy cycles until it drops (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int cycles);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.sign = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        total = 0;
        bad = 0;
        vecs[0] = '{32'd7,          32'd6,          1'b0, 2,  64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 2,  64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 16, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1,  64'h0000_0000_0000_0001};
        vecs[4] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 16, 64'h4000_0000_0000_0000};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 16, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'h1234_5678,  32'd0,          1'b0, 0,  64'd0};

        reset = 1'b1;
        bus.A = '0;
        bus.B = '0;
        bus.sign = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, cyc);
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
            chk($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("result_hold", bus.result, 64'd0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, cyc);
            chk($sformatf("rand%0d_cycles", i), 64'(cyc), 64'(model_cycles(rb, rs)));
            chk($sformatf("rand%0d_result", i), bus.result, model_product(ra, rb, rs));
        end

        // Restart three cycles into a long operation.
        @(negedge clk);
        bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF; bus.sign = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.A = 32'd3; bus.B = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("restart_busy_after_edge", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        chk("restart_busy_done", 64'(bus.busy), 64'd0);
        chk("restart_result", bus.result, 64'd9);

        // Start held high: restarts every edge, finishes only after it drops.
        @(negedge clk);
        bus.A = 32'd7; bus.B = 32'd6; bus.sign = 1'b0; bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held_busy%0d", k), 64'(bus.busy), 64'd1);
        end
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("held_cycles", 64'(cyc), 64'd2);
        chk("held_result", bus.result, 64'd42);

        // Asynchronous reset mid-operation, with a start ignored during reset.
        @(negedge clk);
        bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF; bus.sign = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(bus.busy), 64'd0);
        chk("async_reset_result", bus.result, 64'd0);
        @(negedge clk);
        bus.A = 32'd3; bus.B = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("start_in_reset_busy", 64'(bus.busy), 64'd0);
        chk("start_in_reset_result", bus.result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(bus.busy), 64'd0);
        chk("post_reset_result", bus.result, 64'd0);

        run_op(32'd3, 32'd3, 1'b1, cyc);
        chk("post_reset_op_result", bus.result, 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
